// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high; digit enables are active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] DIG_OFF  = 2'b11;
  localparam logic [1:0] DIG_LOW  = 2'b10;
  localparam logic [1:0] DIG_HIGH = 2'b01;

  typedef enum logic {
    SLOT_LOW  = 1'b0,
    SLOT_HIGH = 1'b1
  } slot_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment scanner with frame-synchronous digit capture.
// Optional blinking is built only when SEG7_BLINK_EN is defined.
//
// sel state | meaning
// SLOT_LOW  | units digit slot, dig = 2'b10 after blanking
// SLOT_HIGH | tens digit slot, dig = 2'b01 after blanking; its tick ends the frame
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK     = 4,
  parameter int BLINK_DIV = 128
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] q_high,
  input  logic [3:0] q_low,
  input  logic       lzb,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt;
  slot_t         sel;
  logic [3:0]    hold_high;
  logic [3:0]    hold_low;
  logic          tick;
  logic          frame_end;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          dark;

  assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = tick && (sel == SLOT_HIGH);
  assign cur_digit = (sel == SLOT_HIGH) ? hold_high : hold_low;

  seg7_dec u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FW-1:0] frame_cnt;
  logic          blink_ph;

  // Counts frame ends regardless of blink so the phase stays frame-aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign dark = blink && blink_ph;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign dark         = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt   <= '0;
      sel       <= SLOT_LOW;
      hold_high <= 4'd0;
      hold_low  <= 4'd0;
      seg       <= SEG_OFF;
      dig       <= DIG_OFF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sel <= (sel == SLOT_LOW) ? SLOT_HIGH : SLOT_LOW;
      end
      // Both digits captured together only at frame end, so a pair is never torn.
      if (frame_end) begin
        hold_high <= q_high;
        hold_low  <= q_low;
      end
      if ((div_cnt < DW'(BLANK)) || dark) begin
        seg <= SEG_OFF;
        dig <= DIG_OFF;
      end else if (sel == SLOT_HIGH) begin
        dig <= DIG_HIGH;
        seg <= (lzb && (hold_high == 4'd0)) ? SEG_OFF : dec_seg;
      end else begin
        dig <= DIG_LOW;
        seg <= dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a slot/frame arithmetic model predicts each output cycle.
// Define SEG7_BLINK_EN for both bench and RTL to exercise the blink build.
module tb_seg7_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK     = 2;
  localparam int BLINK_DIV = 2;
  localparam int N_CYC     = 1600;

  logic       CLK;
  logic       RST;
  logic [3:0] q_high;
  logic [3:0] q_low;
  logic       lzb;
  logic       blink;
  logic [6:0] seg;
  logic [1:0] dig;

  seg7_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK     (BLANK),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .q_high (q_high),
    .q_low  (q_low),
    .lzb    (lzb),
    .blink  (blink),
    .seg    (seg),
    .dig    (dig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [8:0] exp_q[$];
  int         cyc_q[$];
  int         checks = 0;
  int         passes = 0;

  // Model: time since reset, frames completed and the captured digit pair.
  int         t      = 0;
  int         frames = 0;
  int         mh     = 0;
  int         ml     = 0;

  function automatic logic [6:0] ref_pattern(int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic predict(input int c);
    int pos;
    int slot;
    bit dark_now;
    logic [1:0] e_dig;
    logic [6:0] e_seg;
    if (RST) begin
      e_dig  = 2'b11;
      e_seg  = 7'h00;
      t      = 0;
      frames = 0;
      mh     = 0;
      ml     = 0;
    end else begin
      pos  = t % SCAN_DIV;
      slot = (t / SCAN_DIV) % 2;
`ifdef SEG7_BLINK_EN
      dark_now = blink && (((frames / BLINK_DIV) % 2) == 1);
`else
      dark_now = 1'b0;
`endif
      if (pos < BLANK || dark_now) begin
        e_dig = 2'b11;
        e_seg = 7'h00;
      end else if (slot == 1) begin
        e_dig = 2'b01;
        e_seg = (lzb && mh == 0) ? 7'h00 : ref_pattern(mh);
      end else begin
        e_dig = 2'b10;
        e_seg = ref_pattern(ml);
      end
      if (pos == SCAN_DIV - 1 && slot == 1) begin
        mh = int'(q_high);
        ml = int'(q_low);
        frames++;
      end
      t++;
    end
    exp_q.push_back({e_dig, e_seg});
    cyc_q.push_back(c);
  endtask

  // Monitor: every cycle the DUT presents a new registered output.
  initial begin
    logic [8:0] e;
    int         c;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        checks++;
        if ({dig, seg} === e) passes++;
        else $display("FAIL scan_out cyc=%0d actual dig=%b seg=%h required dig=%b seg=%h",
                      c, dig, seg, e[8:7], e[6:0]);
      end
    end
  end

  initial begin
    RST = 1'b1; q_high = 4'd5; q_low = 4'd3; lzb = 1'b0; blink = 1'b0;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge CLK);
      if (c < 3) begin
        RST = 1'b1; q_high = 4'd5; q_low = 4'd3;
      end else if (c < 51) begin
        RST = 1'b0; q_high = 4'd4; q_low = 4'd2; lzb = 1'b0; blink = 1'b0;
      end else if (c < 91) begin
        q_high = 4'd1; q_low = (c < 70) ? 4'd7 : 4'd8;
      end else if (c < 201) begin
        q_high = 4'd0;
        lzb    = (c < 140);
        q_low  = (c < 120) ? 4'd6 : 4'd12;
      end else if (c < 401) begin
        blink  = 1'b1;
        lzb    = 1'b0;
        q_high = 4'($urandom_range(0, 15));
        q_low  = 4'($urandom_range(0, 15));
        RST    = (c == 333);
      end else begin
        q_high = 4'($urandom_range(0, 15));
        q_low  = 4'($urandom_range(0, 15));
        lzb    = 1'($urandom_range(0, 1));
        if ((c % 37) == 0) blink = 1'($urandom_range(0, 1));
        RST    = ($urandom_range(0, 199) == 0);
      end
      predict(c);
    end
    @(posedge CLK);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles per digit slot.
REQ-002 The block SHALL have parameter BLANK, default 4: leading cycles of each slot with both digits off; legal range 0 <= BLANK < SCAN_DIV.
REQ-003 The block SHALL have parameter BLINK_DIV, default 128: scan frames per blink half-period.
REQ-004 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port q_high, input, 4 bits: BCD tens digit from the upstream two-digit counter.
REQ-007 Port q_low, input, 4 bits: BCD units digit from the upstream counter.
REQ-008 Port lzb, input, 1 bit: leading-zero blank enable.
REQ-009 Port blink, input, 1 bit: blink request; the port exists in all builds.
REQ-010 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-high.
REQ-011 Port dig, output, 2 bits: digit enables, active-low; dig[0] is units, dig[1] is tens.

Function
REQ-012 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted when div_cnt == SCAN_DIV-1.
REQ-013 Slot select sel SHALL toggle on tick: sel=0 is the units slot, sel=1 is the tens slot; one frame is two slots.
REQ-014 On a tick with sel=1 (frame end), q_high and q_low SHALL be captured together into hold registers; the hold registers SHALL NOT change at any other time, so digit pairs are never torn.
REQ-015 seg and dig SHALL be registered and reflect the sel and div_cnt state of the previous cycle (latency 1).
REQ-016 While div_cnt < BLANK, the block SHALL drive dig=2'b11 and seg=0.
REQ-017 Otherwise the block SHALL drive dig=2'b10 for sel=0 or dig=2'b01 for sel=1, with seg equal to the decoded hold digit.
REQ-018 The decoder SHALL map 0-9 to the standard patterns (0=7'h3F, 1=7'h06, 8=7'h7F) and map 10-15 to dash (7'h40).
REQ-019 When lzb=1 and the held tens digit is 0, the tens slot SHALL drive seg=0 while dig still follows REQ-017.
REQ-020 lzb SHALL be sampled combinationally each cycle and SHALL NOT be captured.

Reset
REQ-021 While RST=1: div_cnt=0, sel=0, hold registers=0, blink state=0, seg=0, dig=2'b11.
REQ-022 Reset SHALL take priority over every other event, including mid-frame, mid-blank and mid-blink.
REQ-023 After RST falls, the first output cycle SHALL be the start of a units slot, with blanking applied per REQ-016.

Configuration
REQ-024 With SEG7_BLINK_EN defined, a frame counter SHALL count frame ends modulo BLINK_DIV and toggle a blink phase on each wrap.
REQ-025 With SEG7_BLINK_EN defined, while blink=1 and the blink phase=1 the block SHALL force dig=2'b11 and seg=0; the counter SHALL run regardless of blink.
REQ-026 Without SEG7_BLINK_EN, the blink input SHALL be ignored, and no frame counter or blink phase register SHALL be synthesized.

Structure
REQ-027 Package seg7_pkg SHALL hold the segment pattern constants (digits 0-9, dash, off) and the dig encodings (OFF=2'b11, LOW=2'b10, HIGH=2'b01).
REQ-028 The implementation SHALL contain one sub-module, seg7_dec: a combinational 4-bit BCD to 7-bit seg decoder using seg7_pkg, instantiated once and fed by the sel-muxed hold digit.

Verification (SCAN_DIV=8, BLANK=2, BLINK_DIV=2)
REQ-029 Hold RST=1 for 3 cycles with q_high=5, q_low=3 -> seg=0 and dig=2'b11 throughout; after release, slot 1 shows units=0 from the cleared holds, and values 5/3 appear only after the first frame end.
REQ-030 Hold q_high=4, q_low=2 steady -> each 8-cycle slot shows 2 cycles of dig=2'b11, then 6 cycles of dig=2'b10 with seg=7'h5B, then the same for dig=2'b01 with seg=7'h66.
REQ-031 Change q_low from 7 to 8 mid-frame -> the display keeps 7 until the frame-end tick, then shows 8; tens and units never mismatch within a frame.
REQ-032 Apply q_high=0, lzb=1 -> the tens slot shows seg=0 with dig=2'b01; with lzb=0 it shows seg=7'h3F; with q_low=12 the units slot shows 7'h40.
REQ-033 With SEG7_BLINK_EN, set blink=1 -> the display alternates 2 frames visible and 2 frames dark (dig=2'b11); without the macro it is always visible.
REQ-034 Assert RST for one cycle mid-slot and mid-blink -> the next cycle matches the post-reset state exactly and the scan restarts per REQ-023.
